keycode_sequencer: RTL and testbench
====================================

// Module: keycode_sequencer
// PURPOSE
// - Records live USB-HID keycode changes with tick timestamps and replays them as one-cycle keycode events.
// - Sits between the USB keycode source and the keycode consumers (octave/note parsers).
// - Consumers act on every cycle a keycode is present, so all output is edge events:
//   keycode for exactly one cycle, 8'h00 otherwise.
// PARAMETERS
// - DEPTH    32          event buffer entries (power of 2)
// - CLK_HZ   50_000_000  Clk frequency
// - TICK_HZ  1000        timestamp resolution; prescale P = CLK_HZ/TICK_HZ clocks per tick
// - TS_W     16          delta-timestamp width in ticks
// PORTS
// - Clk          in   1                  clock
// - Reset        in   1                  synchronous, active-high
// - keycode_in   in   8                  live keycode, level (held value)
// - rec_start    in   1                  pulse: begin recording
// - play_start   in   1                  pulse: begin playback
// - stop         in   1                  pulse: abort record/play
// - keycode_out  out  8                  event keycode, one cycle, else 8'h00
// - key_valid    out  1                  high in the same cycle keycode_out != 0
// - state_o      out  2                  IDLE=0, RECORD=1, PLAY=2
// - count_o      out  $clog2(DEPTH)+1    entries stored
// - overflow     out  1                  sticky; set when a record hits DEPTH, cleared by rec_start
// BEHAVIOUR
// - Reset: state IDLE, keycode_out=0, key_valid=0, count_o=0, overflow=0, prev_key=0, prescaler=0.
// - Edge detect: live event when keycode_in != prev_key (prev_key registered every cycle).
// - IDLE/RECORD: each live event with new key != 0 drives keycode_out=new key one cycle later.
//   Releases (new key 0) emit nothing.
// - PLAY: live events are not forwarded; prev_key still tracks.
// - Commands are accepted only in IDLE, except stop (any state).
//   Same-cycle priority: stop > rec_start > play_start.
// - rec_start: count_o<=0, overflow<=0, prescaler and delta<=0, -> RECORD.
// - RECORD: every live event (including release) writes {key, delta}; count++; delta<=0.
//   delta counts ticks since the previous write or rec_start, saturating at 2^TS_W-1.
// - RECORD at count==DEPTH: the next event is discarded, overflow<=1, -> IDLE.
// - play_start with count_o==0 is ignored. Otherwise idx<=0, wait<=0, prescaler<=0, -> PLAY.
// - PLAY: entry idx fires in the cycle that wait==delta[idx]; wait<=0 and idx++ in that cycle.
//   delta 0 fires in the first PLAY cycle.
//   Firing a non-zero key: keycode_out=key registered, visible the next cycle.
//   Firing a 0 key: silent, timing still consumed.
// - PLAY end at idx==count_o: -> IDLE (loop behaviour under CONFIGURATION).
// - stop: -> IDLE next cycle; buffer and count kept.
//   A pending event already registered still emits; no new events are generated.
// - stop during RECORD keeps the entries written so far.
// - Reset mid-operation: all of the above reset values apply; buffer contents are don't-care.
// - Buffer: single-port synchronous RAM; write in RECORD, read-ahead of idx in PLAY (1-cycle read).
// CONFIGURATION
// - KEYSEQ_LOOP_EN defined: adds input port loop (1 bit).
//   PLAY reaching idx==count_o with loop=1 sets idx<=0, wait<=0 and stays in PLAY seamlessly.
//   Entry 0's delta is measured from the last fire.
// - KEYSEQ_LOOP_EN undefined: no loop port; playback always ends in IDLE.
// STRUCTURE
// - keyseq_pkg: state enum seq_state_t {IDLE, RECORD, PLAY}; struct seq_entry_t {key[7:0], delta[TS_W-1:0]};
//   localparam KEY_NONE=8'h00; keycodes KEY_OCT_UP=8'h2C, KEY_OCT_DN=8'h2D for benches.
// - Sub-module keyseq_tick_gen: P-clock prescaler, sync clear input, one-cycle tick output.
// - FSM, edge detect and RAM stay in keycode_sequencer.
// TESTING
// - Test bench uses CLK_HZ=1000, TICK_HZ=100 (P=10 clocks/tick) and DEPTH=4.
// 1. Live passthrough: keycode_in 00->2C held 5 cycles -> 00.
//    Expect keycode_out=2C exactly one cycle, one cycle after the change; nothing on release.
// 2. Record then play:
//    Stimulus: rec_start; 2C at tick 3, 00 at tick 5, 2D at tick 9; stop. count_o=3.
//    Expect on play_start: 2C at ~30 clocks, 2D 60 clocks later, then state IDLE.
// 3. Overflow, DEPTH=4: five events during RECORD -> count_o=4, overflow=1, state IDLE.
//    Next rec_start clears overflow.
// 4. Priority and ignore cases:
//    stop+rec_start same cycle -> IDLE; rec_start+play_start -> RECORD;
//    play_start with count 0 -> stays IDLE; rec_start while PLAY -> ignored.
// 5. Saturation with TS_W=4: 20 ticks idle before the first key -> stored delta=15;
//    replay fires at tick 15.
// 6. KEYSEQ_LOOP_EN with loop=1: two-entry pattern repeats at least 3 times with no extra gap;
//    stop mid-wait -> no further events.
//    Also Reset mid-PLAY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/keyseq_pkg.sv
// keyseq_pkg: shared types and constants for the keycode sequencer.
// Entry deltas are stored at TS_MAX_W bits; a sequencer built with a narrower
// TS_W zero-extends its deltas into this field.
package keyseq_pkg;

  localparam int TS_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [7:0]          key;
    logic [TS_MAX_W-1:0] delta;
  } seq_entry_t;

  localparam logic [7:0] KEY_NONE   = 8'h00;
  localparam logic [7:0] KEY_OCT_UP = 8'h2C;
  localparam logic [7:0] KEY_OCT_DN = 8'h2D;

endpackage

// File: rtl/keyseq_if.sv
// keyseq_if: keycode source/consumer side of the sequencer.
// master = controlling side (drives keys and commands), slave = sequencer.
// With KEYSEQ_LOOP_EN defined the bundle carries a loop enable.
interface keyseq_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    keycode_in;
  logic          rec_start;
  logic          play_start;
  logic          stop;
`ifdef KEYSEQ_LOOP_EN
  logic          loop;
`endif
  logic [7:0]    keycode_out;
  logic          key_valid;
  logic [1:0]    state_o;
  logic [CW-1:0] count_o;
  logic          overflow;

  modport master (
`ifdef KEYSEQ_LOOP_EN
    output loop,
`endif
    output keycode_in, rec_start, play_start, stop,
    input  keycode_out, key_valid, state_o, count_o, overflow
  );

  modport slave (
`ifdef KEYSEQ_LOOP_EN
    input  loop,
`endif
    input  keycode_in, rec_start, play_start, stop,
    output keycode_out, key_valid, state_o, count_o, overflow
  );

endinterface

// File: rtl/keyseq_tick_gen.sv
// keyseq_tick_gen: divides Clk by P into a one-cycle tick.
// clr restarts the count so the first tick lands P cycles after the clear.
module keyseq_tick_gen #(
  parameter int P = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] TC = PW'(P - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // next count and terminal-count tick
  always_comb begin
    tick  = !clr && (cnt_q == TC);
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == TC) cnt_d = '0;
  end

  // prescaler register
  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keycode_sequencer.sv
// keycode_sequencer: forwards live keycode presses as one-cycle events, records
// keycode changes with tick deltas, and replays them on the same timing.
// Build option KEYSEQ_LOOP_EN: adds a loop input that restarts playback from
// entry 0 instead of returning to IDLE.
//
// state  | meaning
// IDLE   | live presses forwarded; rec_start/play_start accepted
// RECORD | live presses forwarded; every keycode change stored with its delta
// PLAY   | live input muted; stored entries fired when their delta elapses
module keycode_sequencer
  import keyseq_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int TS_W    = 16
) (
  input logic     Clk,
  input logic     Reset,
  keyseq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int P  = CLK_HZ / TICK_HZ;
  localparam logic [TS_W-1:0] DELTA_MAX = '1;

  seq_state_t    state_q, state_d;
  logic [7:0]    prev_key_q, prev_key_d;
  logic [7:0]    keycode_out_q, keycode_out_d;
  logic          key_valid_q, key_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [TS_W-1:0] delta_q, delta_d;
  logic [TS_W-1:0] wait_q, wait_d;

  logic          tick, tick_clr;
  logic          live_ev, loop_en;
  logic          cmd_rec, cmd_play;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  seq_entry_t    ram_wdata;
  seq_entry_t    ram_q [DEPTH];
  seq_entry_t    rd_q;

`ifdef KEYSEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
`endif

  keyseq_tick_gen #(.P(P)) u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // next-state, edge detect, recording and playback decisions
  always_comb begin
    live_ev  = (bus.keycode_in != prev_key_q);
    cmd_rec  = (state_q == IDLE) && !bus.stop && bus.rec_start;
    cmd_play = (state_q == IDLE) && !bus.stop && !bus.rec_start &&
               bus.play_start && (count_q != '0);

    state_d        = state_q;
    prev_key_d     = bus.keycode_in;
    keycode_out_d  = KEY_NONE;
    count_d        = count_q;
    idx_d          = idx_q;
    overflow_d     = overflow_q;
    delta_d        = delta_q;
    wait_d         = wait_q;
    tick_clr       = 1'b0;
    ram_we         = 1'b0;
    ram_wdata.key   = bus.keycode_in;
    ram_wdata.delta = TS_MAX_W'(delta_q);

    if (state_q != PLAY && live_ev && bus.keycode_in != KEY_NONE)
      keycode_out_d = bus.keycode_in;

    if (tick && delta_q != DELTA_MAX) delta_d = delta_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cmd_rec) begin
          state_d    = RECORD;
          count_d    = '0;
          overflow_d = 1'b0;
          delta_d    = '0;
          tick_clr   = 1'b1;
        end else if (cmd_play) begin
          state_d  = PLAY;
          idx_d    = '0;
          wait_d   = '0;
          tick_clr = 1'b1;
        end
      end
      RECORD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (live_ev) begin
          if (count_q == CW'(DEPTH)) begin
            overflow_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ram_we  = 1'b1;
            count_d = count_q + 1'b1;
            // a tick landing on the write cycle belongs to the next delta
            delta_d = tick ? TS_W'(1) : '0;
          end
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (rd_q.delta == TS_MAX_W'(wait_q)) begin
          keycode_out_d = rd_q.key;
          wait_d        = tick ? TS_W'(1) : '0;
          if (idx_q + 1'b1 == count_q) begin
            idx_d = '0;
            if (!loop_en) state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tick) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // writes go to the next free slot; otherwise read ahead for the next idx
    ram_addr    = ram_we ? count_q[AW-1:0] : idx_d[AW-1:0];
    key_valid_d = (keycode_out_d != KEY_NONE);
  end

  // FSM and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      prev_key_q    <= KEY_NONE;
      keycode_out_q <= KEY_NONE;
      key_valid_q   <= 1'b0;
      count_q       <= '0;
      idx_q         <= '0;
      overflow_q    <= 1'b0;
      delta_q       <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      prev_key_q    <= prev_key_d;
      keycode_out_q <= keycode_out_d;
      key_valid_q   <= key_valid_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      overflow_q    <= overflow_d;
      delta_q       <= delta_d;
      wait_q        <= wait_d;
    end
  end

  // single-port event buffer, contents not reset
  always_ff @(posedge Clk) begin
    if (ram_we) ram_q[ram_addr] <= ram_wdata;
    rd_q <= ram_q[ram_addr];
  end

  assign bus.keycode_out = keycode_out_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.state_o     = state_q;
  assign bus.count_o     = count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_keycode_sequencer.sv
// tb_keycode_sequencer: directed checks of live passthrough, record/replay
// timing, overflow, command priority, delta saturation and reset.
// Clk period 10, P = 10 clocks per tick, DEPTH = 4, TS_W = 4.
// With KEYSEQ_LOOP_EN defined the looping playback is exercised as well.
module tb_keycode_sequencer;
  import keyseq_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   kv_err = 0;
  int   t0 = 0;
  int   ev_cyc[$];
  logic [7:0] ev_key[$];

  keyseq_if #(.DEPTH(4)) bus ();

  keycode_sequencer #(
    .DEPTH   (4),
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .TS_W    (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // event log and key_valid consistency, sampled mid-cycle
  always @(negedge Clk) begin
    if (bus.keycode_out != KEY_NONE) begin
      ev_cyc.push_back(cyc);
      ev_key.push_back(bus.keycode_out);
    end
    if (Reset === 1'b0 && bus.key_valid !== (bus.keycode_out != KEY_NONE)) kv_err++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    t0 = cyc;
    ev_cyc.delete();
    ev_key.delete();
  endtask

  task automatic at(input int rel);
    while (cyc < t0 + rel) @(negedge Clk);
  endtask

  function automatic int ek(input int i);
    if (i < ev_key.size()) return int'(ev_key[i]);
    return -1;
  endfunction

  function automatic int et(input int i);
    if (i < ev_cyc.size()) return ev_cyc[i] - t0;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset          = 1'b1;
    bus.keycode_in = KEY_NONE;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
`ifdef KEYSEQ_LOOP_EN
    bus.loop       = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check("rst_state", int'(bus.state_o), 0);
    check("rst_keyout", int'(bus.keycode_out), 0);
    check("rst_valid", int'(bus.key_valid), 0);
    check("rst_count", int'(bus.count_o), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // 1: live passthrough
    mark(); bus.keycode_in = KEY_OCT_UP;
    at(5);  bus.keycode_in = KEY_NONE;
    at(10);
    check("t1_nev", ev_cyc.size(), 1);
    check("t1_key", ek(0), 8'h2C);
    check("t1_lat", et(0), 1);

    // 2: record 2C@tick3, 00@tick5, 2D@tick9, then replay
    mark(); bus.rec_start = 1'b1;
    at(1);  bus.rec_start = 1'b0;
    at(2);  check("t2_rec_state", int'(bus.state_o), 1);
    at(35); bus.keycode_in = KEY_OCT_UP;
    at(55); bus.keycode_in = KEY_NONE;
    at(95); bus.keycode_in = KEY_OCT_DN;
    at(100); bus.stop = 1'b1;
    at(101); bus.stop = 1'b0;
    at(102);
    check("t2_count", int'(bus.count_o), 3);
    check("t2_idle", int'(bus.state_o), 0);
    bus.keycode_in = KEY_NONE;
    at(104);
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0;
    at(10); check("t2_play_state", int'(bus.state_o), 2);
    at(120);
    check("t2_nev", ev_cyc.size(), 2);
    check("t2_key0", ek(0), 8'h2C);
    check("t2_t0", et(0), 32);
    check("t2_key1", ek(1), 8'h2D);
    check("t2_t1", et(1), 92);
    check("t2_end_state", int'(bus.state_o), 0);
    check("t2_count_kept", int'(bus.count_o), 3);

    // 3: overflow with five events
    mark(); bus.rec_start = 1'b1;
    at(1);  bus.rec_start = 1'b0;
    at(3);  bus.keycode_in = 8'h04;
    at(6);  bus.keycode_in = 8'h05;
    at(9);  bus.keycode_in = 8'h06;
    at(12); bus.keycode_in = 8'h07;
    at(15); bus.keycode_in = 8'h08;
    at(17);
    check("t3_count", int'(bus.count_o), 4);
    check("t3_ovf", int'(bus.overflow), 1);
    check("t3_state", int'(bus.state_o), 0);
    bus.keycode_in = KEY_NONE;
    at(18); bus.rec_start = 1'b1;
    at(19); bus.rec_start = 1'b0;
    check("t3_ovf_clr", int'(bus.overflow), 0);
    check("t3_count_clr", int'(bus.count_o), 0);
    check("t3_rerec", int'(bus.state_o), 1);
    bus.stop = 1'b1;
    at(20); bus.stop = 1'b0;
    at(21); check("t3_stopped", int'(bus.state_o), 0);

    // 4: priorities and ignored commands
    mark(); bus.stop = 1'b1; bus.rec_start = 1'b1;
    at(1);  bus.stop = 1'b0; bus.rec_start = 1'b0;
    check("t4_stop_pri", int'(bus.state_o), 0);
    bus.play_start = 1'b1;
    at(2);  bus.play_start = 1'b0;
    check("t4_play_empty", int'(bus.state_o), 0);
    mark(); bus.rec_start = 1'b1; bus.play_start = 1'b1;
    at(1);  bus.rec_start = 1'b0; bus.play_start = 1'b0;
    check("t4_rec_pri", int'(bus.state_o), 1);
    at(25); bus.keycode_in = KEY_OCT_UP;
    at(30); bus.stop = 1'b1;
    at(31); bus.stop = 1'b0;
    at(32); bus.keycode_in = KEY_NONE;
    check("t4_count", int'(bus.count_o), 1);
    at(34);
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0; bus.rec_start = 1'b1;
    at(2);  bus.rec_start = 1'b0;
    check("t4_rec_in_play", int'(bus.state_o), 2);
    check("t4_count_kept", int'(bus.count_o), 1);
    at(40);
    check("t4_nev", ev_cyc.size(), 1);
    check("t4_key", ek(0), 8'h2C);
    check("t4_t", et(0), 22);
    check("t4_end", int'(bus.state_o), 0);
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0;
    at(10); bus.stop = 1'b1;
    at(11); bus.stop = 1'b0;
    at(12); check("t4_stop_play", int'(bus.state_o), 0);
    at(50); check("t4_stop_noev", ev_cyc.size(), 0);

    // 5: delta saturation at 15 ticks
    mark(); bus.rec_start = 1'b1;
    at(1);  bus.rec_start = 1'b0;
    at(205); bus.keycode_in = KEY_OCT_DN;
    at(210); bus.stop = 1'b1;
    at(211); bus.stop = 1'b0;
    at(212); bus.keycode_in = KEY_NONE;
    check("t5_count", int'(bus.count_o), 1);
    at(214);
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0;
    at(160);
    check("t5_nev", ev_cyc.size(), 1);
    check("t5_key", ek(0), 8'h2D);
    check("t5_t", et(0), 152);
    check("t5_end", int'(bus.state_o), 0);

`ifdef KEYSEQ_LOOP_EN
    // 6: looping playback of 2C(delta 1), 2D(delta 2), then stop mid-wait
    mark(); bus.rec_start = 1'b1;
    at(1);  bus.rec_start = 1'b0;
    at(15); bus.keycode_in = KEY_OCT_UP;
    at(35); bus.keycode_in = KEY_OCT_DN;
    at(40); bus.stop = 1'b1;
    at(41); bus.stop = 1'b0;
    at(42); bus.keycode_in = KEY_NONE;
    check("t6_count", int'(bus.count_o), 2);
    at(44);
    bus.loop = 1'b1;
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0;
    at(127); bus.stop = 1'b1;
    at(128); bus.stop = 1'b0;
    at(200);
    begin
      int exp_t[8] = '{12, 32, 42, 62, 72, 92, 102, 122};
      check("t6_nev", ev_cyc.size(), 8);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t6_key%0d", i), ek(i), (i % 2 == 0) ? 8'h2C : 8'h2D);
        check($sformatf("t6_t%0d", i), et(i), exp_t[i]);
      end
    end
    check("t6_end", int'(bus.state_o), 0);
`endif

    // reset in the middle of playback
    mark(); bus.play_start = 1'b1;
    at(1);  bus.play_start = 1'b0;
    at(100); check("rp_pre_state", int'(bus.state_o), 2);
    Reset = 1'b1;
    at(101); Reset = 1'b0;
    check("rp_state", int'(bus.state_o), 0);
    check("rp_count", int'(bus.count_o), 0);
    check("rp_keyout", int'(bus.keycode_out), 0);
    check("rp_valid", int'(bus.key_valid), 0);
    check("rp_ovf", int'(bus.overflow), 0);
    at(110);

    check("kv_consistency", kv_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
